// File: rtl/mem_dma_engine_if.sv
// Data-memory port of the block-copy engine: address, write data/strobe, read enable and
// combinational read data. The engine drives it as master; the memory (or port mux) is the slave.
interface mem_dma_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_access_adr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_access_adr,
        output mem_write_data,
        output mem_write_en,
        output mem_read,
        input  mem_read_data
    );

    modport slave (
        input  mem_access_adr,
        input  mem_write_data,
        input  mem_write_en,
        input  mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/mem_dma_engine.sv
// Block-copy DMA initiator: moves word_cnt 16-bit words from src to dst, one read then one write per word.
// Optional macro DMA_FILL_EN adds fill_en/fill_data: writes a constant pattern and skips the reads.
module mem_dma_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_adr,
    input  logic [ADDR_W-1:0] dst_adr,
    input  logic [CNT_W-1:0]  word_cnt,
`ifdef DMA_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    mem_dma_engine_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_ptr_reg;
    logic [ADDR_W-1:0] dst_ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] data_reg;
    logic              start_fill;
    logic              fill_mode;

`ifdef DMA_FILL_EN
    logic fill_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            fill_reg <= fill_en;
        end
    end

    assign start_fill = fill_en;
    assign fill_mode  = fill_reg;
`else
    assign start_fill = 1'b0;
    assign fill_mode  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // cnt_reg still holds the current word during WRITE, so 1 means this is the last one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (word_cnt == '0) begin
                        state_next = DONE;
                    end else if (start_fill) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:  state_next = WRITE;
            WRITE: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end else if (fill_mode) begin
                    state_next = WRITE;
                end else begin
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            cnt_reg     <= '0;
            data_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_ptr_reg <= {src_adr[ADDR_W-1:1], 1'b0};
                        dst_ptr_reg <= {dst_adr[ADDR_W-1:1], 1'b0};
                        cnt_reg     <= word_cnt;
`ifdef DMA_FILL_EN
                        data_reg    <= fill_data;
`endif
                    end
                end
                READ: begin
                    data_reg    <= mem.mem_read_data;
                    src_ptr_reg <= src_ptr_reg + ADDR_W'(2);
                end
                WRITE: begin
                    dst_ptr_reg <= dst_ptr_reg + ADDR_W'(2);
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, so reset clears them immediately.
    always_comb begin
        busy               = 1'b0;
        done               = 1'b0;
        mem.mem_read       = 1'b0;
        mem.mem_write_en   = 1'b0;
        mem.mem_access_adr = '0;
        mem.mem_write_data = '0;
        case (state_reg)
            READ: begin
                busy               = 1'b1;
                mem.mem_read       = 1'b1;
                mem.mem_access_adr = src_ptr_reg;
            end
            WRITE: begin
                busy               = 1'b1;
                mem.mem_write_en   = 1'b1;
                mem.mem_access_adr = dst_ptr_reg;
                mem.mem_write_data = data_reg;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Scoreboard bench for mem_dma_engine: a word-level copy model predicts every memory operation
// and busy length; a negedge monitor compares them against the memory port. Fill tests need DMA_FILL_EN.
module tb_mem_dma_engine;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    localparam int WORDS  = 32768;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_adr = '0;
    logic [ADDR_W-1:0] dst_adr = '0;
    logic [CNT_W-1:0]  word_cnt = '0;
    logic              busy;
    logic              done;
`ifdef DMA_FILL_EN
    logic              fill_en = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
`endif

    mem_dma_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

    mem_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_adr  (src_adr),
        .dst_adr  (dst_adr),
        .word_cnt (word_cnt),
`ifdef DMA_FILL_EN
        .fill_en  (fill_en),
        .fill_data(fill_data),
`endif
        .busy     (busy),
        .done     (done),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] adr;
        logic [15:0] data;
    } op_t;

    op_t  exp_ops[$];
    int   exp_busy[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] ram      [0:WORDS-1];
    logic [15:0] init_mem [0:WORDS-1];
    logic [15:0] ref_mem  [0:WORDS-1];
    logic        load_req = 1'b0;

    assign mem.mem_read_data = mem.mem_read ? ram[mem.mem_access_adr[15:1]] : '0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_mem[i];
        end else if (mem.mem_write_en) begin
            ram[mem.mem_access_adr[15:1]] <= mem.mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one line per memory operation, compared against the scoreboard queue.
    initial begin : monitor
        int  busy_cnt;
        op_t op;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                check("rw_exclusive", 32'(mem.mem_read & mem.mem_write_en), 32'd0);
                if (mem.mem_read || mem.mem_write_en) begin
                    if (exp_ops.size() == 0) begin
                        check("unexpected_op", 32'(exp_ops.size()), 32'd1);
                    end else begin
                        op = exp_ops.pop_front();
                        $display("op %s adr=%04h data=%04h", mem.mem_write_en ? "WR" : "RD",
                                 mem.mem_access_adr, mem.mem_write_en ? mem.mem_write_data : mem.mem_read_data);
                        check("op_kind", 32'(mem.mem_write_en), 32'(op.is_wr));
                        check("op_adr", 32'(mem.mem_access_adr), 32'(op.adr));
                        if (op.is_wr) check("wr_data", 32'(mem.mem_write_data), 32'(op.data));
                    end
                end else begin
                    check("idle_adr", 32'(mem.mem_access_adr), 32'd0);
                    check("idle_wdata", 32'(mem.mem_write_data), 32'd0);
                end
                if (busy) busy_cnt++;
                if (done) begin
                    check("done_in_busy", 32'(busy), 32'd1);
                    if (exp_busy.size() == 0) begin
                        check("done_expected", 32'(exp_busy.size()), 32'd1);
                    end else begin
                        check("busy_len", 32'(busy_cnt), 32'(exp_busy.pop_front()));
                    end
                    busy_cnt = 0;
                end else if (!busy && busy_cnt != 0) begin
                    check("done_missing", 32'(done), 32'd1);
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic randomize_init();
        for (int i = 0; i < WORDS; i++) begin
            init_mem[i] = 16'($urandom);
            ref_mem[i]  = init_mem[i];
        end
    endtask

    task automatic commit_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Reference model: ascending word-by-word copy (or fill) over a 16-bit wrapping byte address.
    task automatic model_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                              input bit fill, input logic [15:0] fd);
        logic [15:0] sp, dp, v;
        sp = s & 16'hFFFE;
        dp = d & 16'hFFFE;
        for (int i = 0; i < n; i++) begin
            if (fill) begin
                v = fd;
            end else begin
                v = ref_mem[sp[15:1]];
                exp_ops.push_back('{1'b0, sp, 16'h0000});
                sp = sp + 16'd2;
            end
            ref_mem[dp[15:1]] = v;
            exp_ops.push_back('{1'b1, dp, v});
            dp = dp + 16'd2;
        end
        exp_busy.push_back(n == 0 ? 1 : (fill ? n + 1 : 2 * n + 1));
    endtask

    task automatic issue_start(input logic [15:0] s, input logic [15:0] d, input int n,
                               input bit fill, input logic [15:0] fd);
        @(negedge clk);
        start    = 1'b1;
        src_adr  = s;
        dst_adr  = d;
        word_cnt = CNT_W'(n);
`ifdef DMA_FILL_EN
        fill_en   = fill;
        fill_data = fd;
`endif
        $display("xfer src=%04h dst=%04h cnt=%0d fill=%0d data=%04h", s, d, n, fill, fd);
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_adr  = 16'($urandom);
        dst_adr  = 16'($urandom);
        word_cnt = 8'($urandom);
`ifdef DMA_FILL_EN
        fill_en   = 1'($urandom);
        fill_data = 16'($urandom);
`endif
    endtask

    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                            input bit fill, input logic [15:0] fd, input bit interfere);
        int k;
        model_xfer(s, d, n, fill, fd);
        issue_start(s, d, n, fill, fd);
        @(negedge clk);
        check("start_latency", 32'(busy), 32'd1);
        if (interfere) begin
            @(negedge clk);
            if (busy) begin
                start    = 1'b1;
                src_adr  = 16'($urandom);
                dst_adr  = 16'($urandom);
                word_cnt = 8'($urandom_range(1, 255));
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        k = 0;
        while (busy && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("xfer_timeout", 32'(busy), 32'd0);
        @(negedge clk);
        check("ops_drained", 32'(exp_ops.size()), 32'd0);
        check("busy_drained", 32'(exp_busy.size()), 32'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          k;
        int          nmis;
        logic [14:0] widx;
        logic [15:0] saved;

        // Reset state while rst_n is held low.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(mem.mem_read), 32'd0);
        check("rst_wen", 32'(mem.mem_write_en), 32'd0);
        check("rst_adr", 32'(mem.mem_access_adr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        randomize_init();
        commit_load();

        // Asynchronous reset in the middle of a WRITE cycle.
        model_xfer(16'h0300, 16'h0400, 3, 1'b0, 16'h0);
        issue_start(16'h0300, 16'h0400, 3, 1'b0, 16'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem.mem_write_en && k < 20);
        check("saw_write", 32'(mem.mem_write_en), 32'd1);
        widx  = mem.mem_access_adr[15:1];
        saved = ram[widx];
        #2 rst_n = 1'b0;
        #1;
        check("arst_wen", 32'(mem.mem_write_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_adr", 32'(mem.mem_access_adr), 32'd0);
        exp_ops.delete();
        exp_busy.delete();
        @(posedge clk);
        #1 check("no_partial_write", 32'(ram[widx]), 32'(saved));
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_after_reset", 32'(busy), 32'd0);
        end

        // Directed 4-word copy from a known preload.
        randomize_init();
        for (int i = 0; i < 4; i++) begin
            init_mem[8 + i] = 16'hA001 + 16'(i);
            ref_mem[8 + i]  = init_mem[8 + i];
        end
        commit_load();
        run_xfer(16'h0010, 16'h0040, 4, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) check("copy4_ram", 32'(ram[16'h20 + i]), 32'hA001 + 32'(i));

        run_xfer(16'h1234, 16'h2000, 0, 1'b0, 16'h0, 1'b0);   // zero words: a lone DONE cycle
        run_xfer(16'hFFFC, 16'h0200, 3, 1'b0, 16'h0, 1'b0);   // source pointer wraps to 0x0000
        run_xfer(16'h0500, 16'h0600, 5, 1'b0, 16'h0, 1'b1);   // re-pulsed start is ignored
        run_xfer(16'h0101, 16'h0105, 6, 1'b0, 16'h0, 1'b0);   // forward overlap, odd addresses

        for (int t = 0; t < 25; t++) begin
            run_xfer(16'($urandom), 16'($urandom), int'($urandom_range(0, 12)),
                     1'b0, 16'h0, 1'($urandom));
        end

`ifdef DMA_FILL_EN
        run_xfer(16'h0000, 16'h0100, 3, 1'b1, 16'h5A5A, 1'b0);
        for (int i = 0; i < 3; i++) check("fill_ram", 32'(ram[16'h80 + i]), 32'h5A5A);
        for (int t = 0; t < 8; t++) begin
            run_xfer(16'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
                     1'($urandom), 16'($urandom), 1'($urandom));
        end
`endif

        nmis = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) nmis++;
        check("final_mem_mismatches", 32'(nmis), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
